// File: rtl/room_thermal_model.sv
// Room plant model: temperature ramps with heat/cool commands and drifts toward ambient when idle.
// Latency: inputs act on the next rising edge; each step follows a per-mode prescaler of DIV edges.
// Backpressure: none; the model accepts a command every cycle and never stalls the controller.
module room_thermal_model #(
    parameter int unsigned INIT_TEMP = 16,
    parameter int unsigned AMBIENT   = 12,
    parameter int unsigned HEAT_DIV  = 2,
    parameter int unsigned COOL_DIV  = 2,
    parameter int unsigned DRIFT_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_heating,
    input  logic       i_cooling,
    output logic [4:0] o_temperature,
    output logic       o_changed,
    output logic       o_fault
);

    typedef enum logic [1:0] {
        MODE_DRIFT = 2'd0,
        MODE_HEAT  = 2'd1,
        MODE_COOL  = 2'd2,
        MODE_BOTH  = 2'd3
    } mode_t;

    localparam logic [4:0] L_INIT    = 5'(INIT_TEMP);
    localparam logic [4:0] L_AMBIENT = 5'(AMBIENT);
    localparam logic [4:0] L_MAX     = 5'd31;

    mode_t      r_mode;
    logic [7:0] r_cnt;
    logic [4:0] r_temp;
    logic       r_changed;
    logic       r_fault;

    mode_t      w_mode;
    mode_t      w_mode_nxt;
    logic [7:0] w_div;
    logic [4:0] w_step_temp;
    logic [7:0] w_cnt_nxt;
    logic [4:0] w_temp_nxt;
    logic       w_changed_nxt;
    logic       w_fault_nxt;

    always_comb begin
        w_mode = MODE_DRIFT;
        unique case ({i_heating, i_cooling})
            2'b10:   w_mode = MODE_HEAT;
            2'b01:   w_mode = MODE_COOL;
            2'b11:   w_mode = MODE_BOTH;
            default: w_mode = MODE_DRIFT;
        endcase
    end

    always_comb begin
        w_div = 8'(DRIFT_DIV);
        unique case (r_mode)
            MODE_HEAT: w_div = 8'(HEAT_DIV);
            MODE_COOL: w_div = 8'(COOL_DIV);
            default:   w_div = 8'(DRIFT_DIV);
        endcase
    end

    // Saturating step for the currently held mode; an unchanged value is not reported as a change.
    always_comb begin
        w_step_temp = r_temp;
        unique case (r_mode)
            MODE_HEAT: w_step_temp = (r_temp == L_MAX) ? r_temp : r_temp + 5'd1;
            MODE_COOL: w_step_temp = (r_temp == 5'd0)  ? r_temp : r_temp - 5'd1;
            MODE_DRIFT: begin
                if (r_temp < L_AMBIENT)
                    w_step_temp = r_temp + 5'd1;
                else if (r_temp > L_AMBIENT)
                    w_step_temp = r_temp - 5'd1;
                else
                    w_step_temp = r_temp;
            end
            default:   w_step_temp = r_temp;
        endcase
    end

    always_comb begin
        w_mode_nxt    = r_mode;
        w_cnt_nxt     = r_cnt;
        w_temp_nxt    = r_temp;
        w_changed_nxt = 1'b0;
        w_fault_nxt   = r_fault | (i_heating & i_cooling);
        if (w_mode != r_mode) begin
            w_mode_nxt = w_mode;
            w_cnt_nxt  = 8'd0;
        end else if (w_mode == MODE_BOTH) begin
            w_cnt_nxt = 8'd0;
        end else if (r_cnt == w_div - 8'd1) begin
            w_cnt_nxt     = 8'd0;
            w_temp_nxt    = w_step_temp;
            w_changed_nxt = (w_step_temp != r_temp);
        end else begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode    <= MODE_DRIFT;
            r_cnt     <= 8'd0;
            r_temp    <= L_INIT;
            r_changed <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_cnt     <= w_cnt_nxt;
            r_temp    <= w_temp_nxt;
            r_changed <= w_changed_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign o_temperature = r_temp;
    assign o_changed     = r_changed;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model: default instance plus a DIV=1 instance sharing the same inputs.
module tb_room_thermal_model;

    logic       clk;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic [4:0] temperature;
    logic       changed;
    logic       fault;
    logic [4:0] f_temperature;
    logic       f_changed;
    logic       f_fault;

    int n_checks = 0;
    int n_errors = 0;

    room_thermal_model u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_heating     (heating),
        .i_cooling     (cooling),
        .o_temperature (temperature),
        .o_changed     (changed),
        .o_fault       (fault)
    );

    room_thermal_model #(
        .HEAT_DIV  (1),
        .COOL_DIV  (1),
        .DRIFT_DIV (1)
    ) u_fast (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_heating     (heating),
        .i_cooling     (cooling),
        .o_temperature (f_temperature),
        .o_changed     (f_changed),
        .o_fault       (f_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        int exp_t;
        int exp_c;
        int any_bad;

        // Reset and idle drift toward ambient 12, one step every 8 edges.
        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        tick(2);
        check("rst_temp", int'(temperature), 16);
        check("rst_changed", int'(changed), 0);
        check("rst_fault", int'(fault), 0);
        rst = 1'b0;
        tick(7);
        check("drift_e7_temp", int'(temperature), 16);
        tick(1);
        check("drift_e8_temp", int'(temperature), 15);
        check("drift_e8_changed", int'(changed), 1);
        tick(1);
        check("drift_e9_changed", int'(changed), 0);
        tick(7);
        check("drift_e16_temp", int'(temperature), 14);
        tick(16);
        check("drift_e32_temp", int'(temperature), 12);
        any_bad = 0;
        for (int e = 0; e < 24; e++) begin
            tick(1);
            if (changed !== 1'b0 || temperature !== 5'd12) any_bad = 1;
        end
        check("drift_hold_at_ambient", any_bad, 0);

        // Heat ramp: +1 on edge 3 then every 2 edges, saturating at 31 by edge 31.
        do_reset();
        heating = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            exp_t = (e < 3) ? 16 : 16 + (e - 1) / 2;
            if (exp_t > 31) exp_t = 31;
            exp_c = (e >= 3 && (e % 2) == 1 && e <= 31) ? 1 : 0;
            check($sformatf("heat_e%0d_temp", e), int'(temperature), exp_t);
            check($sformatf("heat_e%0d_changed", e), int'(changed), exp_c);
            exp_t = 16 + e - 1;
            if (exp_t > 31) exp_t = 31;
            exp_c = (e >= 2 && e <= 16) ? 1 : 0;
            check($sformatf("heat_div1_e%0d_temp", e), int'(f_temperature), exp_t);
            check($sformatf("heat_div1_e%0d_changed", e), int'(f_changed), exp_c);
        end

        // Cool ramp: -1 on edge 3 then every 2 edges, reaching 0 on edge 33.
        do_reset();
        cooling = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            exp_t = (e < 3) ? 16 : 16 - (e - 1) / 2;
            if (exp_t < 0) exp_t = 0;
            exp_c = (e >= 3 && (e % 2) == 1 && e <= 33) ? 1 : 0;
            check($sformatf("cool_e%0d_temp", e), int'(temperature), exp_t);
            check($sformatf("cool_e%0d_changed", e), int'(changed), exp_c);
            check($sformatf("cool_e%0d_fault", e), int'(fault), 0);
        end

        // Both asserted for one cycle mid heat ramp.
        do_reset();
        heating = 1'b1;
        tick(5);
        check("both_pre_temp", int'(temperature), 18);
        cooling = 1'b1;
        tick(1);
        check("both_fault", int'(fault), 1);
        check("both_temp_held", int'(temperature), 18);
        check("both_changed", int'(changed), 0);
        cooling = 1'b0;
        tick(2);
        check("both_resume_e2_temp", int'(temperature), 18);
        tick(1);
        check("both_resume_e3_temp", int'(temperature), 19);
        tick(10);
        check("both_fault_sticky", int'(fault), 1);
        do_reset();
        check("both_fault_cleared", int'(fault), 0);

        // Reset in the middle of a heat ramp, with heating still asserted.
        heating = 1'b1;
        tick(13);
        check("midrst_pre_temp", int'(temperature), 22);
        rst = 1'b1;
        tick(1);
        check("midrst_temp", int'(temperature), 16);
        check("midrst_changed", int'(changed), 0);
        check("midrst_fault", int'(fault), 0);
        rst = 1'b0;
        tick(2);
        check("midrst_after_e2_temp", int'(temperature), 16);
        tick(1);
        check("midrst_after_e3_temp", int'(temperature), 17);

        // One-cycle cooling glitch restarts the heat prescaler.
        do_reset();
        heating = 1'b1;
        tick(2);
        check("glitch_pre_temp", int'(temperature), 16);
        heating = 1'b0;
        cooling = 1'b1;
        tick(1);
        check("glitch_temp", int'(temperature), 16);
        check("glitch_changed", int'(changed), 0);
        heating = 1'b1;
        cooling = 1'b0;
        tick(1);
        check("glitch_resume_e1_temp", int'(temperature), 16);
        tick(1);
        check("glitch_resume_e2_temp", int'(temperature), 16);
        tick(1);
        check("glitch_resume_e3_temp", int'(temperature), 17);
        check("glitch_resume_e3_changed", int'(changed), 1);
        check("glitch_fault", int'(fault), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/room_thermal_model.md
# room_thermal_model

Synthesisable room plant model for the air-conditioning exercise: consumes the `heating`/`cooling` commands produced by the thermostat controller and drives back the 5-bit `temperature` it regulates, closing the loop on-chip. Temperature ramps up while heating, ramps down while cooling, and drifts toward an ambient value when neither is active. Illegal simultaneous heating and cooling raises a sticky `fault` flag.

## Interface
- `INIT_TEMP`, 16: temperature loaded on reset (0..31)
- `AMBIENT`, 12: drift target when idle (0..31)
- `HEAT_DIV`, 2: cycles per +1 step while heating (1..255)
- `COOL_DIV`, 2: cycles per −1 step while cooling (1..255)
- `DRIFT_DIV`, 8: cycles per 1-degree step toward `AMBIENT` while idle (1..255)

- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `heating`  in  1  heater command from the controller
- `cooling`  in  1  cooler command from the controller
- `temperature`  out  5  current modelled room temperature, unsigned degrees, registered
- `changed`  out  1  one-cycle pulse: `temperature` was updated on this edge
- `fault`  out  1  sticky: heating and cooling were both sampled high since reset

## Operation
- Mode is decoded combinationally from the inputs: HEAT (`heating` only), COOL (`cooling` only), DRIFT (neither), BOTH (both).
- Registered state: `mode_q` (HEAT/COOL/DRIFT/BOTH), 8-bit prescaler `cnt`, `temperature`, `changed`, `fault`.
- Each rising edge with `rst`=0, in priority order:
  - Decoded mode ≠ `mode_q`: `mode_q` ← mode, `cnt` ← 0, no temperature step.
  - Else mode BOTH: `cnt` held at 0, temperature held.
  - Else `cnt` = DIV(mode) − 1: `cnt` ← 0, temperature step is applied.
  - Else: `cnt` ← `cnt` + 1.
- Step rules:
  - HEAT: +1, saturating at 31.
  - COOL: −1, saturating at 0.
  - DRIFT: +1 if below `AMBIENT`, −1 if above, no change if equal.
- `changed` = 1 for exactly the cycle following an edge on which `temperature` actually changed value. A saturated or at-ambient "step" is not a change.
- `fault` ← 1 on any edge sampling `heating`=`cooling`=1. It clears only on reset.
- DIV=1: a step is applied on every edge after the mode-entry edge.

## Timing
- Reset values, one edge after `rst` is sampled high:
  - `temperature` = `INIT_TEMP`
  - `mode_q` = DRIFT, `cnt` = 0
  - `changed` = 0, `fault` = 0
- Reset overrides all inputs, including mid-ramp and while in BOTH.
- Inputs are sampled only at the rising edge. There are no combinational paths from inputs to outputs.
- On entering a mode held steadily, the first step lands on edge DIV+1, counting the entry edge as edge 1. Later steps follow every DIV edges.
- A mode change of any length, including a one-cycle glitch, restarts the prescaler. Partial counts are discarded.
- Leaving reset with inputs idle is not a mode change, because the reset mode is DRIFT. The first drift step lands on edge `DRIFT_DIV` after reset deasserts.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles, `heating`=`cooling`=0 → `temperature`=16, `changed`=0, `fault`=0. Then release with inputs idle → `temperature`=15 after 8 edges, 14 after 16, 12 after 32, then held at 12 with no further `changed` pulses.
2. **Heat ramp and saturation:** from 16, `heating`=1 held → `temperature`=17 on edge 3, 18 on edge 5, …, 31 on edge 31. It stays at 31 thereafter, with `changed`=0 after reaching 31.
3. **Cool ramp and saturation:** from 16, `cooling`=1 held → 15 on edge 3, then −1 every 2 edges, reaching 0 on edge 33 and held at 0. `fault` stays 0 throughout.
4. **Both asserted:** `heating`=`cooling`=1 for one cycle mid heat ramp → `fault`=1 from the next edge, `temperature` unchanged that cycle. After returning to heating only, the next step occurs 3 edges later, and `fault` remains 1 until `rst`.
5. **Reset mid-operation:** `heating`=1 until `temperature`=22, then `rst`=1 for one edge → `temperature`=16, `changed`=0, `fault`=0, `cnt`=0 on that edge.
6. **Prescaler restart:** `heating`=1 for 2 edges, then `cooling`=1 for 1 edge, then `heating`=1 held → no step during the glitch. The first +1 lands 3 edges after heating resumes, with `temperature` unchanged before that.
